// File: rtl/numlock_btn_debouncer.sv
// Push-button conditioner: two-flop synchroniser, bounce filter and the
// single / repeating / continuous enable pulses used by the numlock FSM.
module numlock_btn_debouncer #(
   parameter int CNT_W         = 25,
   parameter int DB_CYCLES     = 1048576,
   parameter int HOLD_CYCLES   = 16777216,
   parameter int REPEAT_CYCLES = 4194304
) (
   input  logic clk,
   input  logic reset,
   input  logic PB,
   output logic DPB,
   output logic SCEN,
   output logic MCEN,
   output logic CCEN
);

   // state    | meaning
   // ---------+-------------------------------------------------------
   // INI      | released and idle, waiting for a high sample
   // W84      | press candidate, counting DB_CYCLES stable highs
   // SCEN_ST  | press accepted, one-cycle SCEN + MCEN
   // WS       | held after SCEN, counting HOLD_CYCLES before repeats
   // MCEN_ST  | one-cycle repeat MCEN pulse
   // MCEN_CNT | held, counting REPEAT_CYCLES until the next repeat
   // CCR      | release candidate, counting DB_CYCLES stable lows
   typedef enum logic [2:0] {
      INI      = 3'd0,
      W84      = 3'd1,
      SCEN_ST  = 3'd2,
      WS       = 3'd3,
      MCEN_ST  = 3'd4,
      MCEN_CNT = 3'd5,
      CCR      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic             s1;
   logic             pb_s;
   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             dpb_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b0;
         pb_s <= 1'b0;
      end else begin
         s1   <= PB;
         pb_s <= s1;
      end
   end

   // Counter clears by default so every state change starts from zero.
   always_comb begin
      nxt     = state;
      cnt_nxt = '0;
      case (state)
         INI: begin
            if (pb_s) nxt = W84;
         end
         W84: begin
            if (!pb_s)              nxt = INI;
            else if (cnt == DB_LAST) nxt = SCEN_ST;
            else                    cnt_nxt = cnt + CNT_W'(1);
         end
         SCEN_ST: begin
            nxt = pb_s ? WS : CCR;
         end
         WS: begin
            if (!pb_s)                nxt = CCR;
            else if (cnt == HOLD_LAST) nxt = MCEN_ST;
            else                      cnt_nxt = cnt + CNT_W'(1);
         end
         MCEN_ST: begin
            nxt = pb_s ? MCEN_CNT : CCR;
         end
         MCEN_CNT: begin
            if (!pb_s)                  nxt = CCR;
            else if (cnt == REPEAT_LAST) nxt = MCEN_ST;
            else                        cnt_nxt = cnt + CNT_W'(1);
         end
         CCR: begin
            // A high sample during release restarts the stable-low count.
            if (pb_s)                cnt_nxt = '0;
            else if (cnt == DB_LAST) nxt = INI;
            else                     cnt_nxt = cnt + CNT_W'(1);
         end
         default: begin
            nxt = INI;
         end
      endcase
   end

   always_comb begin
      dpb_nxt = 1'b0;
      case (nxt)
         SCEN_ST, WS, MCEN_ST, MCEN_CNT, CCR: dpb_nxt = 1'b1;
         default:                             dpb_nxt = 1'b0;
      endcase
   end

   // Outputs are registered from the next state, so they always match a
   // Moore decode of the state register without any combinational path.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INI;
         cnt   <= '0;
         DPB   <= 1'b0;
         SCEN  <= 1'b0;
         MCEN  <= 1'b0;
         CCEN  <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= cnt_nxt;
         DPB   <= dpb_nxt;
         SCEN  <= (nxt == SCEN_ST);
         MCEN  <= (nxt == SCEN_ST) || (nxt == MCEN_ST);
         CCEN  <= dpb_nxt;
      end
   end

endmodule

// File: tb/tb_numlock_btn_debouncer.sv
// Bench for numlock_btn_debouncer: directed latency checks plus random button
// activity compared every cycle against a run-length reference model.
module tb_numlock_btn_debouncer;

   localparam int DB   = 4;
   localparam int HOLD = 8;
   localparam int REP  = 3;

   logic clk = 1'b0;
   logic reset;
   logic PB;
   logic DPB, SCEN, MCEN, CCEN;

   int n_checks = 0;
   int n_fail   = 0;

   numlock_btn_debouncer #(
      .CNT_W         (4),
      .DB_CYCLES     (DB),
      .HOLD_CYCLES   (HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .PB    (PB),
      .DPB   (DPB),
      .SCEN  (SCEN),
      .MCEN  (MCEN),
      .CCEN  (CCEN)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference model: the synchronised level is PB delayed two edges; a press
   // is DB+1 consecutive high samples; once pressed, the number of high samples
   // since acceptance gives the MCEN schedule; the first low starts a release
   // that completes after DB consecutive lows following it.
   bit m_valid = 0;
   bit m_s1, m_s2, smp;
   bit m_press, m_pend, m_scen, m_mcen;
   int m_hr, m_lows, m_t;

   always @(posedge clk) begin
      m_scen = 0;
      m_mcen = 0;
      if (reset) begin
         m_valid = 1;
         m_s1 = 0; m_s2 = 0;
         m_press = 0; m_pend = 0;
         m_hr = 0; m_lows = 0; m_t = 0;
      end else begin
         smp  = m_s2;
         m_hr = smp ? m_hr + 1 : 0;
         if (!m_press) begin
            if (m_hr == DB + 1) begin
               m_press = 1; m_pend = 0; m_t = 0;
               m_scen = 1; m_mcen = 1;
            end
         end else if (m_pend) begin
            m_lows = smp ? 0 : m_lows + 1;
            if (m_lows == DB) begin
               m_press = 0; m_pend = 0;
            end
         end else if (!smp) begin
            m_pend = 1; m_lows = 0;
         end else begin
            m_t++;
            if (m_t >= HOLD + 1 && (m_t - (HOLD + 1)) % (REP + 1) == 0) m_mcen = 1;
         end
         m_s2 = m_s1;
         m_s1 = PB;
      end
   end

   always @(negedge clk) begin
      if (m_valid)
         chk("outputs", {28'd0, DPB, SCEN, MCEN, CCEN}, {28'd0, m_press, m_scen, m_mcen, m_press});
   end

   task automatic hold(input logic v, input int n);
      PB = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic scen_latency(input string tag);
      int lat;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (SCEN && lat == 0) lat = n;
      end
      chk(tag, lat, 7);
   endtask

   initial begin
      logic [2:0] e;
      int kind, len, reps;

      PB    = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Reset held with the button pressed, then first SCEN 7 edges later.
      hold(1'b1, 3);
      chk("rst_hold_outs", {28'd0, DPB, SCEN, MCEN, CCEN}, 32'd0);
      reset = 1'b0;
      scen_latency("rst_rel_scen_lat");
      hold(1'b0, 30);

      // Long hold: MCEN schedule 7, 16, 20, 24, 28.
      PB = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk);
         #1;
         e[2] = (n >= 7);
         e[1] = (n == 7);
         e[0] = (n == 7) || (n == 16) || (n == 20) || (n == 24) || (n == 28);
         chk("hold_pattern", {29'd0, DPB, SCEN, MCEN}, {29'd0, e});
      end

      // Reset while repeating, then a fresh press with the button still held.
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_outs", {28'd0, DPB, SCEN, MCEN, CCEN}, 32'd0);
      reset = 1'b0;
      scen_latency("rst_mid_scen_lat");
      hold(1'b0, 30);

      // Bounce 1,1,0,0 never gets accepted.
      for (int k = 0; k < 40; k++) begin
         PB = ((k % 4) < 2);
         @(posedge clk);
         #1;
         chk("bounce_quiet", {29'd0, DPB, SCEN, MCEN}, 32'd0);
      end
      hold(1'b0, 10);

      // Clean press and release-bounce, checked by the model.
      hold(1'b1, 12);
      hold(1'b0, 20);
      hold(1'b1, 12);
      hold(1'b0, 2);
      hold(1'b1, 1);
      hold(1'b0, 20);

      // Random activity.
      for (int seg = 0; seg < 150; seg++) begin
         kind = $urandom_range(0, 9);
         if (kind < 3) begin
            hold(1'b1, $urandom_range(1, 40));
         end else if (kind < 5) begin
            hold(1'b0, $urandom_range(1, 12));
         end else if (kind < 8) begin
            reps = $urandom_range(2, 12);
            for (int k = 0; k < reps; k++) begin
               len = $urandom_range(1, 4);
               hold(1'($urandom_range(0, 1)), len);
            end
         end else if (kind == 8) begin
            reset = 1'b1;
            hold(PB, $urandom_range(1, 3));
            reset = 1'b0;
         end else begin
            hold(1'b1, $urandom_range(20, 60));
         end
      end
      hold(1'b0, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
